// File: rtl/accl_pkg.sv
// Shared types and latency constants for the gravitational-acceleration kernel.
package accl_pkg;

  typedef logic [63:0] fp64_t;

  localparam fp64_t FP_ZERO = 64'h0;

  localparam int unsigned MULT_TIME    = 11;
  localparam int unsigned ADD_TIME     = 20;
  localparam int unsigned INVSQRT_TIME = 27;

  typedef enum logic [1:0] {
    FP_ADD,
    FP_SUB,
    FP_MUL
  } fp_op_e;

  function automatic int unsigned accl_latency(input int unsigned add_t,
                                               input int unsigned inv_t,
                                               input int unsigned mult_t);
    return 2 * add_t + inv_t + 4 * mult_t;
  endfunction

  // True for both +0 and -0.
  function automatic logic fp_is_zero(input fp64_t v);
    return (v[62:0] == 63'h0);
  endfunction

endpackage

// File: rtl/fp_cores.sv
// Latency-accurate behavioural stand-ins for the vendor FP64 add/sub, multiply and
// inverse-square-root cores; the vendor IP replaces these in the implementation flow.
module fp_arith
  import accl_pkg::*;
#(
  parameter fp_op_e      OP  = FP_ADD,
  parameter int unsigned LAT = 1
) (
  input  logic  clk,
  input  fp64_t a_i,
  input  fp64_t b_i,
  output fp64_t y_o
);

  fp64_t res_d;
  fp64_t pipe_q [LAT];

  always_comb begin
    res_d = $realtobits($bitstoreal(a_i) + $bitstoreal(b_i));
    if (OP == FP_SUB)      res_d = $realtobits($bitstoreal(a_i) - $bitstoreal(b_i));
    else if (OP == FP_MUL) res_d = $realtobits($bitstoreal(a_i) * $bitstoreal(b_i));
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= res_d;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign y_o = pipe_q[LAT-1];

endmodule

module fp_invsqrt
  import accl_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic  clk,
  input  fp64_t a_i,
  output fp64_t y_o
);

  fp64_t res_d;
  fp64_t pipe_q [LAT];

  always_comb res_d = $realtobits(1.0 / $sqrt($bitstoreal(a_i)));

  always_ff @(posedge clk) begin
    pipe_q[0] <= res_d;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign y_o = pipe_q[LAT-1];

endmodule

// File: rtl/fp_delay_line.sv
// Resettable shift register used to keep operands and flags cycle-aligned with the FP cores.
module fp_delay_line #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/get_accl.sv
// Fully pipelined FP64 kernel: acceleration on body 1 due to body 2, a = m2*(p2-p1)/|p2-p1|^3.
// One body pair per clock, fixed latency, coincident bodies yield +0.
module get_accl
  import accl_pkg::*;
#(
  parameter int unsigned MultTime    = MULT_TIME,
  parameter int unsigned AddTime     = ADD_TIME,
  parameter int unsigned InvSqrtTime = INVSQRT_TIME
) (
  input  logic  clk,
  input  logic  rst,
  input  fp64_t x1,
  input  fp64_t y1,
  input  fp64_t x2,
  input  fp64_t y2,
  input  fp64_t m2,
  output fp64_t ax,
  output fp64_t ay
);

  localparam int unsigned LATENCY = accl_latency(AddTime, InvSqrtTime, MultTime);
  localparam int unsigned DXY_DLY = MultTime + AddTime + InvSqrtTime;
  localparam int unsigned M2_DLY  = AddTime + DXY_DLY;
  localparam int unsigned ZF_DLY  = InvSqrtTime + 3 * MultTime;

  fp64_t dx, dy, dx2, dy2, r2, ir, ir2, ir3, mdx, mdy, ax_raw, ay_raw;
  fp64_t dx_al, dy_al, m2_al, ir_al, mdx_al, mdy_al;
  logic [127:0] dxy_al, mdxy_al;
  logic  r2_zero, zf_al, out_en;
  logic [LATENCY-1:0] vld_q, vld_d;

  // S1: separation
  fp_arith #(.OP(FP_SUB), .LAT(AddTime)) u_s1_dx (.clk(clk), .a_i(x2), .b_i(x1), .y_o(dx));
  fp_arith #(.OP(FP_SUB), .LAT(AddTime)) u_s1_dy (.clk(clk), .a_i(y2), .b_i(y1), .y_o(dy));

  // S2: squares
  fp_arith #(.OP(FP_MUL), .LAT(MultTime)) u_s2_dx2 (.clk(clk), .a_i(dx), .b_i(dx), .y_o(dx2));
  fp_arith #(.OP(FP_MUL), .LAT(MultTime)) u_s2_dy2 (.clk(clk), .a_i(dy), .b_i(dy), .y_o(dy2));

  // S3: squared distance
  fp_arith #(.OP(FP_ADD), .LAT(AddTime)) u_s3_r2 (.clk(clk), .a_i(dx2), .b_i(dy2), .y_o(r2));

  // S4: inverse distance; the zero flag is raised here and rides alongside to the output
  fp_invsqrt #(.LAT(InvSqrtTime)) u_s4_ir (.clk(clk), .a_i(r2), .y_o(ir));

  assign r2_zero = fp_is_zero(r2);

  fp_delay_line #(.WIDTH(128), .DEPTH(DXY_DLY)) u_dly_dxy (
    .clk(clk), .rst_n(rst), .d_i({dx, dy}), .q_o(dxy_al)
  );
  assign dx_al = dxy_al[127:64];
  assign dy_al = dxy_al[63:0];

  fp_delay_line #(.WIDTH(64), .DEPTH(M2_DLY)) u_dly_m2 (
    .clk(clk), .rst_n(rst), .d_i(m2), .q_o(m2_al)
  );

  fp_delay_line #(.WIDTH(1), .DEPTH(ZF_DLY)) u_dly_zf (
    .clk(clk), .rst_n(rst), .d_i(r2_zero), .q_o(zf_al)
  );

  // S5: ir^2 and mass-scaled separation in parallel
  fp_arith #(.OP(FP_MUL), .LAT(MultTime)) u_s5_ir2 (.clk(clk), .a_i(ir), .b_i(ir), .y_o(ir2));
  fp_arith #(.OP(FP_MUL), .LAT(MultTime)) u_s5_mdx (.clk(clk), .a_i(m2_al), .b_i(dx_al), .y_o(mdx));
  fp_arith #(.OP(FP_MUL), .LAT(MultTime)) u_s5_mdy (.clk(clk), .a_i(m2_al), .b_i(dy_al), .y_o(mdy));

  fp_delay_line #(.WIDTH(64), .DEPTH(MultTime)) u_dly_ir (
    .clk(clk), .rst_n(rst), .d_i(ir), .q_o(ir_al)
  );

  // S6: ir^3; mdx/mdy wait one multiplier latency for it
  fp_arith #(.OP(FP_MUL), .LAT(MultTime)) u_s6_ir3 (.clk(clk), .a_i(ir2), .b_i(ir_al), .y_o(ir3));

  fp_delay_line #(.WIDTH(128), .DEPTH(MultTime)) u_dly_mdxy (
    .clk(clk), .rst_n(rst), .d_i({mdx, mdy}), .q_o(mdxy_al)
  );
  assign mdx_al = mdxy_al[127:64];
  assign mdy_al = mdxy_al[63:0];

  // S7: scale
  fp_arith #(.OP(FP_MUL), .LAT(MultTime)) u_s7_ax (.clk(clk), .a_i(mdx_al), .b_i(ir3), .y_o(ax_raw));
  fp_arith #(.OP(FP_MUL), .LAT(MultTime)) u_s7_ay (.clk(clk), .a_i(mdy_al), .b_i(ir3), .y_o(ay_raw));

  // Output validity: fills with ones after reset, so its MSB marks the first real result.
  assign vld_d = {vld_q[LATENCY-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  assign out_en = vld_q[LATENCY-1] & ~zf_al;
  assign ax     = out_en ? ax_raw : FP_ZERO;
  assign ay     = out_en ? ay_raw : FP_ZERO;

endmodule

// File: tb/tb_get_accl.sv
// Randomised scoreboard bench for get_accl against a real-arithmetic reference model.
module tb_get_accl;
  import accl_pkg::*;

  localparam int unsigned LAT = accl_latency(ADD_TIME, INVSQRT_TIME, MULT_TIME);

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] x1, y1, x2, y2, m2;
  logic [63:0] ax, ay;

  get_accl dut (
    .clk(clk), .rst(rst),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .m2(m2),
    .ax(ax), .ay(ay)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          live;
    int          epoch;
    int          id;
    int          lit;
    logic [63:0] eax;
    logic [63:0] eay;
  } exp_t;

  exp_t pend[$];
  int   epoch   = 0;
  int   id_cnt  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Hand-worked results for the first three directed pairs (index = lit tag).
  real lit_ax[4] = '{0.0, -0.4472136, -0.7071068, 1.9641855};
  real lit_ay[4] = '{0.0, -0.8944272, -0.7071068, 1.9641855};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp,
                     input real tol = 1.0e-9);
    real g, e, lim;
    bit  ok;
    n_tests++;
    if (exp[62:0] == 63'h0) begin
      ok = (got[62:0] == 63'h0);
    end else begin
      g   = $bitstoreal(got);
      e   = $bitstoreal(exp);
      lim = tol * ((e < 0.0) ? -e : e);
      ok  = ((g - e) <= lim) && ((e - g) <= lim);
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h (%g) expected %h (%g)", tag, got, $bitstoreal(got),
               exp, $bitstoreal(exp));
    end
  endtask

  // a = m2*d/r^3, with r taken straight from the Euclidean distance.
  function automatic void ref_accl(input real px1, input real py1, input real px2,
                                   input real py2, input real pm2,
                                   output logic [63:0] rax, output logic [63:0] ray);
    real dx, dy, r2, s;
    dx = px2 - px1;
    dy = py2 - py1;
    r2 = dx * dx + dy * dy;
    if (r2 == 0.0) begin
      rax = 64'h0;
      ray = 64'h0;
    end else begin
      s   = pm2 / (r2 * $sqrt(r2));
      rax = $realtobits(s * dx);
      ray = $realtobits(s * dy);
    end
  endfunction

  // One cycle: check the output due now, apply reset changes, drive the next pair.
  task automatic step(input real px1, input real py1, input real px2, input real py2,
                      input real pm2, input bit rst_v, input int lit);
    exp_t e, f;
    @(negedge clk);
    if (pend.size() == LAT) begin
      f = pend.pop_front();
      if (f.live && f.epoch == epoch) begin
        chk($sformatf("r%0d.ax", f.id), ax, f.eax);
        chk($sformatf("r%0d.ay", f.id), ay, f.eay);
        if (f.lit != 0) begin
          chk($sformatf("T%0d.ax", f.lit), ax, $realtobits(lit_ax[f.lit]), 1.0e-6);
          chk($sformatf("T%0d.ay", f.lit), ay, $realtobits(lit_ay[f.lit]), 1.0e-6);
        end
      end else begin
        chk($sformatf("r%0d.ax_zero", f.id), ax, 64'h0);
        chk($sformatf("r%0d.ay_zero", f.id), ay, 64'h0);
      end
    end
    if (!rst_v && rst) begin
      rst = 1'b0;
      epoch++;
      #1;
      chk("rst_now.ax", ax, 64'h0);
      chk("rst_now.ay", ay, 64'h0);
    end else if (rst_v) begin
      rst = 1'b1;
    end
    x1 = $realtobits(px1);
    y1 = $realtobits(py1);
    x2 = $realtobits(px2);
    y2 = $realtobits(py2);
    m2 = $realtobits(pm2);
    ref_accl(px1, py1, px2, py2, pm2, e.eax, e.eay);
    e.live  = rst_v;
    e.epoch = epoch;
    e.id    = id_cnt++;
    e.lit   = lit;
    pend.push_back(e);
  endtask

  function automatic real rnd(input real lo, input real hi);
    return lo + (hi - lo) * (real'($urandom_range(0, 1000000)) / 1.0e6);
  endfunction

  task automatic rand_step(input bit rst_v);
    real a, b, c, d, m;
    a = rnd(-1000.0, 1000.0);
    b = rnd(-1000.0, 1000.0);
    c = rnd(-1000.0, 1000.0);
    d = rnd(-1000.0, 1000.0);
    m = rnd(1.0, 1.0e6);
    if ($urandom_range(0, 15) == 0) begin
      c = a;
      d = b;
    end
    step(a, b, c, d, m, rst_v, 0);
  endtask

  initial begin
    rst = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; m2 = '0;
    repeat (4) rand_step(1'b0);
    chk("reset.ax", ax, 64'h0);
    chk("reset.ay", ay, 64'h0);

    step(10.0, 20.0, 0.0, 0.0, 500.0, 1'b1, 1);
    step(5.0, 5.0, -5.0, -5.0, 200.0, 1'b1, 2);
    step(1.0, 2.0, 4.0, 5.0, 50.0, 1'b1, 3);

    step(10.0, 20.0, 0.0, 0.0, 500.0, 1'b1, 0);
    step(10.0, 100.0, 0.0, 0.0, 400.0, 1'b1, 0);
    step(10.0, -10.0, 0.0, 0.0, 300.0, 1'b1, 0);
    step(-100.0, 10.0, 0.0, 0.0, 200.0, 1'b1, 0);
    step(1000.0, 1000.0, 0.0, 0.0, 1.0e11, 1'b1, 0);

    step(3.0, -7.0, 3.0, -7.0, 100.0, 1'b1, 0);
    step(0.0, 0.0, 0.0, 0.0, 0.0, 1'b1, 0);

    repeat (300) rand_step(1'b1);
    repeat (3) rand_step(1'b0);
    repeat (LAT + 150) rand_step(1'b1);
    repeat (LAT) rand_step(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
